pcie_dma_rd_desc_arb: RTL and testbench
=======================================

Name: pcie_dma_rd_desc_arb

Overview:
Shares one PCIe DMA read engine's descriptor input among PORTS requesters. Read descriptors are arbitrated round-robin into a single registered output, with the port index packed into the upper tag bits. Completion status is routed back to the originating port by decoding that field. A per-port outstanding-operation credit limit keeps any one requester from occupying the engine's operation table.

Parameters:
PORTS, 4, number of requester ports (2..16)
PCIE_ADDR_WIDTH, 64, descriptor PCIe address width
AXI_ADDR_WIDTH, 64, descriptor AXI address width
LEN_WIDTH, 20, descriptor length width
S_TAG_WIDTH, 6, per-port tag width
CL_PORTS, $clog2(PORTS), port index width
M_TAG_WIDTH, S_TAG_WIDTH+CL_PORTS, engine tag width; must be <= engine TAG_WIDTH
MAX_OUTSTANDING, 16, per-port in-flight descriptor limit (1..2**S_TAG_WIDTH)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
s_axis_read_desc_pcie_addr  in  PORTS*PCIE_ADDR_WIDTH  per-port PCIe address, port i at slice i
s_axis_read_desc_axi_addr  in  PORTS*AXI_ADDR_WIDTH  per-port AXI address
s_axis_read_desc_len  in  PORTS*LEN_WIDTH  per-port length
s_axis_read_desc_tag  in  PORTS*S_TAG_WIDTH  per-port tag
s_axis_read_desc_valid  in  PORTS  per-port valid
s_axis_read_desc_ready  out  PORTS  per-port ready
m_axis_read_desc_status_tag  out  PORTS*S_TAG_WIDTH  returned tag, per port
m_axis_read_desc_status_valid  out  PORTS  per-port status pulse
m_axis_read_desc_pcie_addr  out  PCIE_ADDR_WIDTH  to engine
m_axis_read_desc_axi_addr  out  AXI_ADDR_WIDTH  to engine
m_axis_read_desc_len  out  LEN_WIDTH  to engine
m_axis_read_desc_tag  out  M_TAG_WIDTH  {port index, port tag}
m_axis_read_desc_valid  out  1  to engine
m_axis_read_desc_ready  in  1  from engine
s_axis_read_desc_status_tag  in  M_TAG_WIDTH  from engine
s_axis_read_desc_status_valid  in  1  from engine
enable  in  1  allow new grants
stat_busy  out  1  any port has outstanding > 0 or output valid
stat_error  out  1  one-cycle pulse on a bad status

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0. Credit counters 0, round-robin pointer 0, output register empty. Nothing is reset in the middle of an operation except by rst_n.
- Eligibility: port i is eligible when valid[i]=1, outstanding[i] < MAX_OUTSTANDING, and enable=1.
- Grant timing: a grant occurs in a cycle where the output register is empty, or is being consumed (m_valid & m_ready). At most one grant per cycle.
- Arbitration: round-robin. Search starts at (last_grant+1) mod PORTS; the first eligible port wins and last_grant takes its index.
- s_axis_read_desc_ready is combinational: ready[i]=1 only for the granted port in that cycle. It never depends on valid[j] for j≠i beyond the arbitration result.
- Output register: loaded on grant with the port's fields; tag = {i[CL_PORTS-1:0], tag_i}. m_valid rises the cycle after the grant (latency 1).
  - Contents are held stable while m_valid=1 and m_ready=0 (AXI-stream rules).
  - Back-to-back throughput is one descriptor per cycle.
- enable=0: no new grants. A descriptor already in the output register stays valid until accepted.
- Credit counters: width $clog2(MAX_OUTSTANDING+1).
  - +1 on grant to port i.
  - -1 on status with port field = i.
  - Both in the same cycle: counter unchanged.
  - A port at MAX_OUTSTANDING is ineligible until a status frees a slot. Its freed slot is usable in the next cycle's arbitration, not the same cycle.
- Status demux: port field p = status_tag[M_TAG_WIDTH-1:S_TAG_WIDTH].
  - Valid status: one cycle later, m_status_valid[p] pulses for 1 cycle with m_status_tag slice p = low S_TAG_WIDTH bits. Other slices hold their last value.
  - Bad status: p >= PORTS, or outstanding[p]==0. No pulse is routed, the counter is not decremented (no underflow), and stat_error pulses 1 cycle (registered).
- Ordering: status may return in any order. The arbiter imposes no ordering.
- stat_busy is registered and reflects the state after the current cycle's updates.

Optional Feature:
PCIE_DMA_RD_ARB_FIXED_PRIO_EN
- Defined: round-robin is replaced by fixed priority, where the lowest eligible index wins and last_grant is unused. All credit and status behaviour is unchanged.
- Undefined: round-robin as above.

Test Plan:
- Reset, then ports 0..3 each present one descriptor (tag=5, len=64) simultaneously with m_ready=1. Engine sees tags 0x05,0x45,0x85,0xC5 on 4 consecutive cycles, first one 1 cycle after valid; each ready[i] is high for exactly 1 cycle.
- Port 2 streams 20 descriptors, no status returned, MAX_OUTSTANDING=16. Exactly 16 are accepted and ready[2] stays 0. Return status tag 0x83: next cycle m_status_valid[2] pulses with tag 3, and one more descriptor is accepted on the following cycle.
- Hold m_ready=0 for 5 cycles with output valid. Output fields stay stable, all s_ready=0, then the descriptor is accepted on the cycle m_ready=1.
- Grant to port 1 and status tag 0x40 for port 1 in the same cycle with outstanding[1]=3. Counter stays 3, and status pulse port 1 has tag 0.
- Status tag 0xC0 with outstanding[3]=0. stat_error pulses 1 cycle, no m_status_valid, counter stays 0. Then rst_n low mid-stream with output valid: m_valid=0 and counters=0 immediately.
- With PCIE_DMA_RD_ARB_FIXED_PRIO_EN defined, ports 0 and 3 both continuously valid. Port 0 wins every cycle until it hits its credit limit, then port 3 is granted.

Source files
------------

// File: rtl/pcie_dma_rd_desc_arb.sv
// Round-robin read-descriptor arbiter for a shared PCIe DMA read engine, with per-port
// credit limiting and status demux. Define PCIE_DMA_RD_ARB_FIXED_PRIO_EN for fixed priority.
module pcie_dma_rd_desc_arb #(
  parameter int PORTS           = 4,
  parameter int PCIE_ADDR_WIDTH = 64,
  parameter int AXI_ADDR_WIDTH  = 64,
  parameter int LEN_WIDTH       = 20,
  parameter int S_TAG_WIDTH     = 6,
  parameter int CL_PORTS        = $clog2(PORTS),
  parameter int M_TAG_WIDTH     = S_TAG_WIDTH + CL_PORTS,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [PORTS*PCIE_ADDR_WIDTH-1:0] s_axis_read_desc_pcie_addr,
  input  logic [PORTS*AXI_ADDR_WIDTH-1:0]  s_axis_read_desc_axi_addr,
  input  logic [PORTS*LEN_WIDTH-1:0]       s_axis_read_desc_len,
  input  logic [PORTS*S_TAG_WIDTH-1:0]     s_axis_read_desc_tag,
  input  logic [PORTS-1:0]                 s_axis_read_desc_valid,
  output logic [PORTS-1:0]                 s_axis_read_desc_ready,
  output logic [PORTS*S_TAG_WIDTH-1:0]     m_axis_read_desc_status_tag,
  output logic [PORTS-1:0]                 m_axis_read_desc_status_valid,
  output logic [PCIE_ADDR_WIDTH-1:0]       m_axis_read_desc_pcie_addr,
  output logic [AXI_ADDR_WIDTH-1:0]        m_axis_read_desc_axi_addr,
  output logic [LEN_WIDTH-1:0]             m_axis_read_desc_len,
  output logic [M_TAG_WIDTH-1:0]           m_axis_read_desc_tag,
  output logic                             m_axis_read_desc_valid,
  input  logic                             m_axis_read_desc_ready,
  input  logic [M_TAG_WIDTH-1:0]           s_axis_read_desc_status_tag,
  input  logic                             s_axis_read_desc_status_valid,
  input  logic                             enable,
  output logic                             stat_busy,
  output logic                             stat_error
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  logic [CW-1:0]       cnt     [PORTS];
  logic [CW-1:0]       cnt_nxt [PORTS];
  logic [PORTS-1:0]    elig;
  logic                gnt;
  logic [CL_PORTS-1:0] gnt_idx;
  logic [CL_PORTS-1:0] st_port;
  logic [PORTS-1:0]    st_vec;
  logic                st_good;
  logic                m_valid_nxt;
  logic                busy_nxt;
  int                  idx;
`ifndef PCIE_DMA_RD_ARB_FIXED_PRIO_EN
  // Next port to search first (one past the last grant).
  logic [CL_PORTS-1:0] rr_ptr;
`endif

  always_comb begin
    for (int i = 0; i < PORTS; i++)
      elig[i] = s_axis_read_desc_valid[i] & (cnt[i] < MAX_CNT) & enable;
  end

  always_comb begin
    gnt     = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = 0; k < PORTS; k++) begin
`ifdef PCIE_DMA_RD_ARB_FIXED_PRIO_EN
      idx = k;
`else
      idx = (int'(rr_ptr) + k) % PORTS;
`endif
      if (!gnt && elig[idx]) begin
        gnt     = 1'b1;
        gnt_idx = CL_PORTS'(idx);
      end
    end
    // Reset gating keeps ready low while rst_n is asserted.
    gnt = gnt & rst_n & (~m_axis_read_desc_valid | m_axis_read_desc_ready);
  end

  always_comb begin
    s_axis_read_desc_ready = '0;
    if (gnt) s_axis_read_desc_ready[gnt_idx] = 1'b1;
  end

  assign st_port = s_axis_read_desc_status_tag[M_TAG_WIDTH-1:S_TAG_WIDTH];

  // Out-of-range ports never match, so they fall out as bad status.
  always_comb begin
    st_vec  = '0;
    st_good = 1'b0;
    for (int i = 0; i < PORTS; i++) begin
      if (s_axis_read_desc_status_valid && st_port == CL_PORTS'(i) && cnt[i] != '0) begin
        st_vec[i] = 1'b1;
        st_good   = 1'b1;
      end
    end
  end

  always_comb begin
    m_valid_nxt = gnt | (m_axis_read_desc_valid & ~m_axis_read_desc_ready);
    busy_nxt    = m_valid_nxt;
    for (int i = 0; i < PORTS; i++) begin
      cnt_nxt[i] = cnt[i];
      if ((gnt && gnt_idx == CL_PORTS'(i)) && !st_vec[i])
        cnt_nxt[i] = cnt[i] + 1'b1;
      else if (!(gnt && gnt_idx == CL_PORTS'(i)) && st_vec[i])
        cnt_nxt[i] = cnt[i] - 1'b1;
      if (cnt_nxt[i] != '0) busy_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PORTS; i++) cnt[i] <= '0;
      m_axis_read_desc_valid        <= 1'b0;
      m_axis_read_desc_pcie_addr    <= '0;
      m_axis_read_desc_axi_addr     <= '0;
      m_axis_read_desc_len          <= '0;
      m_axis_read_desc_tag          <= '0;
      m_axis_read_desc_status_valid <= '0;
      m_axis_read_desc_status_tag   <= '0;
      stat_error                    <= 1'b0;
      stat_busy                     <= 1'b0;
`ifndef PCIE_DMA_RD_ARB_FIXED_PRIO_EN
      rr_ptr                        <= '0;
`endif
    end else begin
      for (int i = 0; i < PORTS; i++) cnt[i] <= cnt_nxt[i];
      if (gnt) begin
        m_axis_read_desc_pcie_addr <= s_axis_read_desc_pcie_addr[gnt_idx*PCIE_ADDR_WIDTH +: PCIE_ADDR_WIDTH];
        m_axis_read_desc_axi_addr  <= s_axis_read_desc_axi_addr[gnt_idx*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
        m_axis_read_desc_len       <= s_axis_read_desc_len[gnt_idx*LEN_WIDTH +: LEN_WIDTH];
        m_axis_read_desc_tag       <= {gnt_idx, s_axis_read_desc_tag[gnt_idx*S_TAG_WIDTH +: S_TAG_WIDTH]};
`ifndef PCIE_DMA_RD_ARB_FIXED_PRIO_EN
        rr_ptr <= (gnt_idx == CL_PORTS'(PORTS - 1)) ? '0 : gnt_idx + 1'b1;
`endif
      end
      m_axis_read_desc_valid        <= m_valid_nxt;
      m_axis_read_desc_status_valid <= st_vec;
      for (int i = 0; i < PORTS; i++)
        if (st_vec[i])
          m_axis_read_desc_status_tag[i*S_TAG_WIDTH +: S_TAG_WIDTH] <= s_axis_read_desc_status_tag[S_TAG_WIDTH-1:0];
      stat_error <= s_axis_read_desc_status_valid & ~st_good;
      stat_busy  <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_pcie_dma_rd_desc_arb.sv
// Self-checking bench for pcie_dma_rd_desc_arb: directed scenarios plus random traffic
// against a transaction-level reference model.
module tb_pcie_dma_rd_desc_arb;
  localparam int P = 4;
  localparam int MAXO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [P*64-1:0] s_pa = '0, s_aa = '0;
  logic [P*20-1:0] s_len = '0;
  logic [P*6-1:0]  s_tag = '0;
  logic [P-1:0]    s_valid = '0;
  logic [P-1:0]    s_ready;
  logic [P*6-1:0]  mst_tag;
  logic [P-1:0]    mst_valid;
  logic [63:0]     m_pa, m_aa;
  logic [19:0]     m_len;
  logic [7:0]      m_tag;
  logic            m_valid;
  logic            m_ready = 1'b0;
  logic [7:0]      st_tag = '0;
  logic            st_valid = 1'b0;
  logic            enable = 1'b0;
  logic            stat_busy, stat_error;

  pcie_dma_rd_desc_arb dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_read_desc_pcie_addr(s_pa), .s_axis_read_desc_axi_addr(s_aa),
    .s_axis_read_desc_len(s_len), .s_axis_read_desc_tag(s_tag),
    .s_axis_read_desc_valid(s_valid), .s_axis_read_desc_ready(s_ready),
    .m_axis_read_desc_status_tag(mst_tag), .m_axis_read_desc_status_valid(mst_valid),
    .m_axis_read_desc_pcie_addr(m_pa), .m_axis_read_desc_axi_addr(m_aa),
    .m_axis_read_desc_len(m_len), .m_axis_read_desc_tag(m_tag),
    .m_axis_read_desc_valid(m_valid), .m_axis_read_desc_ready(m_ready),
    .s_axis_read_desc_status_tag(st_tag), .s_axis_read_desc_status_valid(st_valid),
    .enable(enable), .stat_busy(stat_busy), .stat_error(stat_error)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int          r_cnt[P];
  int          r_next;
  bit          r_mv;
  logic [63:0] r_pa, r_aa;
  logic [19:0] r_len;
  logic [7:0]  r_tag;
  logic [P-1:0] r_sv;
  logic [P*6-1:0] r_stag;
  bit          r_err, r_busy;
  logic [P-1:0] exp_ready;
  int          win;

  // Stimulus bookkeeping
  int   rem[P];
  int   dut_acc[P];
  logic [5:0] tag_ctr[P];

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < P; i++) r_cnt[i] = 0;
    r_next = 0; r_mv = 0; r_pa = '0; r_aa = '0; r_len = '0; r_tag = '0;
    r_sv = '0; r_stag = '0; r_err = 0; r_busy = 0;
  endtask

  // Decide this cycle's winner from the visible request set.
  task automatic model_arb();
    bit found = 0;
    win = 0;
    for (int k = 0; k < P; k++) begin
      int j;
`ifdef PCIE_DMA_RD_ARB_FIXED_PRIO_EN
      j = k;
`else
      j = (r_next + k) % P;
`endif
      if (!found && s_valid[j] && enable && r_cnt[j] < MAXO) begin
        found = 1; win = j;
      end
    end
    exp_ready = (found && (!r_mv || m_ready)) ? P'(1 << win) : '0;
  endtask

  task automatic model_clock();
    int p = int'(st_tag[7:6]);
    bit good = st_valid && r_cnt[p] > 0;
    r_sv  = good ? P'(1 << p) : '0;
    if (good) begin
      r_stag[p*6 +: 6] = st_tag[5:0];
      r_cnt[p]--;
    end
    r_err = st_valid && !good;
    if (exp_ready != '0) begin
      r_cnt[win]++;
      r_pa = s_pa[win*64 +: 64]; r_aa = s_aa[win*64 +: 64];
      r_len = s_len[win*20 +: 20]; r_tag = {2'(win), s_tag[win*6 +: 6]};
      r_next = (win + 1) % P;
      r_mv = 1;
    end else if (m_ready) r_mv = 0;
    r_busy = r_mv;
    for (int i = 0; i < P; i++) if (r_cnt[i] > 0) r_busy = 1;
  endtask

  task automatic set_desc(input int i, input logic [5:0] t, input logic [19:0] l);
    s_pa[i*64 +: 64] = {$urandom, $urandom};
    s_aa[i*64 +: 64] = {$urandom, $urandom};
    s_len[i*20 +: 20] = l;
    s_tag[i*6 +: 6] = t;
    s_valid[i] = 1'b1;
  endtask

  task automatic new_desc(input int i);
    set_desc(i, tag_ctr[i], 20'($urandom));
    tag_ctr[i]++;
  endtask

  task automatic step();
    @(negedge clk);
    model_arb();
    chk("s_ready", 64'(s_ready), 64'(exp_ready));
    chk("m_valid", 64'(m_valid), 64'(r_mv));
    if (r_mv) begin
      chk("m_tag", 64'(m_tag), 64'(r_tag));
      chk("m_len", 64'(m_len), 64'(r_len));
      chk("m_pcie_addr", m_pa, r_pa);
      chk("m_axi_addr", m_aa, r_aa);
    end
    chk("status_valid", 64'(mst_valid), 64'(r_sv));
    chk("status_tag", 64'(mst_tag), 64'(r_stag));
    chk("stat_error", 64'(stat_error), 64'(r_err));
    chk("stat_busy", 64'(stat_busy), 64'(r_busy));
    for (int i = 0; i < P; i++) if (s_ready[i]) dut_acc[i]++;
    @(posedge clk);
    model_clock();
    #1;
    st_valid = 1'b0;
    for (int i = 0; i < P; i++) begin
      if (exp_ready[i]) begin
        if (rem[i] > 0) rem[i]--;
        if (rem[i] > 0) new_desc(i); else s_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic send_status(input int p, input logic [5:0] t);
    st_tag = {2'(p), t};
    st_valid = 1'b1;
    step();
  endtask

  task automatic drain();
    for (int n = 0; n < 200; n++) begin
      int p = -1;
      for (int i = 0; i < P; i++) if (p < 0 && r_cnt[i] > 0) p = i;
      if (p < 0) break;
      send_status(p, 6'($urandom));
    end
    step();
  endtask

  initial begin
    int base;
    for (int i = 0; i < P; i++) begin rem[i] = 0; dut_acc[i] = 0; tag_ctr[i] = '0; end
    model_reset();

    // Reset values
    #3;
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_status_valid", 64'(mst_valid), 64'd0);
    chk("rst_busy", 64'(stat_busy), 64'd0);
    chk("rst_error", 64'(stat_error), 64'd0);
    @(posedge clk); #2; rst_n = 1'b1;
    @(posedge clk); #1;
    enable = 1'b1; m_ready = 1'b1;

    // All four ports at once, tag 5, len 64
    for (int i = 0; i < P; i++) begin set_desc(i, 6'd5, 20'd64); rem[i] = 1; end
    repeat (6) step();
    for (int i = 0; i < P; i++) chk("rr_once", 64'(dut_acc[i]), 64'd1);
    drain();

    // Port 2 runs into its credit limit
    base = dut_acc[2];
    rem[2] = 20; new_desc(2);
    repeat (22) step();
    chk("limit_accepted", 64'(dut_acc[2] - base), 64'(MAXO));
    send_status(2, 6'd3);
    step();
    step();
    chk("limit_refill", 64'(dut_acc[2] - base), 64'(MAXO + 1));
    rem[2] = 0; s_valid[2] = 1'b0;
    drain();

    // Backpressure with competing requester
    m_ready = 1'b0;
    rem[0] = 1; new_desc(0); rem[1] = 1; new_desc(1);
    repeat (6) step();
    m_ready = 1'b1;
    repeat (4) step();
    drain();

    // Same-cycle grant and status on port 1
    rem[1] = 3; new_desc(1);
    repeat (4) step();
    rem[1] = 1; new_desc(1);
    st_tag = 8'h40; st_valid = 1'b1;
    step();
    repeat (2) step();
    drain();

    // Bad status to an idle port, then reset mid-stream
    send_status(3, 6'd0);
    repeat (2) step();
    m_ready = 1'b0;
    rem[0] = 3; new_desc(0);
    repeat (2) step();
    chk("pre_rst_valid", 64'(m_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(m_valid), 64'd0);
    chk("async_rst_busy", 64'(stat_busy), 64'd0);
    chk("async_rst_ready", 64'(s_ready), 64'd0);
    model_reset();
    s_valid = '0; rem[0] = 0;
    @(posedge clk); @(posedge clk); #2; rst_n = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b1;
    repeat (2) step();

`ifdef PCIE_DMA_RD_ARB_FIXED_PRIO_EN
    begin
      int b0 = dut_acc[0];
      int b3 = dut_acc[3];
      rem[0] = 100; new_desc(0); rem[3] = 100; new_desc(3);
      repeat (24) step();
      chk("fp_port0", 64'(dut_acc[0] - b0), 64'(MAXO));
      chk("fp_port3", 64'(dut_acc[3] - b3 > 0), 64'd1);
      rem[0] = 0; rem[3] = 0; s_valid = '0;
      drain();
    end
`endif

    // Random traffic
    for (int n = 0; n < 800; n++) begin
      m_ready = ($urandom_range(3) != 0);
      enable  = ($urandom_range(9) != 0);
      for (int i = 0; i < P; i++)
        if (!s_valid[i] && $urandom_range(1) == 0) begin rem[i] = 1; new_desc(i); end
      if ($urandom_range(9) < 4) begin
        int p = int'($urandom_range(P - 1));
        if (r_cnt[p] > 0 || $urandom_range(9) == 0) begin
          st_tag = {2'(p), 6'($urandom)}; st_valid = 1'b1;
        end
      end
      step();
    end
    enable = 1'b1; m_ready = 1'b1; s_valid = '0;
    for (int i = 0; i < P; i++) rem[i] = 0;
    step();
    drain();
    chk("final_idle_busy", 64'(stat_busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
